// File: rtl/rgb_mean_pkg.sv
// Shared types and helpers for the rgb_mean camera front-end.
package rgb_mean_pkg;

  localparam int unsigned CHAN_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StWaitSad
  } state_e;

  // floor((r+g+b)/3); sum*43>>7 is exact over the whole 0..45 range.
  function automatic logic [CHAN_W-1:0] mean3(input logic [CHAN_W-1:0] r,
                                              input logic [CHAN_W-1:0] g,
                                              input logic [CHAN_W-1:0] b);
    logic [5:0] sum;
    sum = {2'b00, r} + {2'b00, g} + {2'b00, b};
    return CHAN_W'((11'(sum) * 11'd43) >> 7);
  endfunction

endpackage

// File: rtl/pixel_edge_sync.sv
// Two-flop synchroniser for the camera pixel strobe plus a rising-edge detector.
module pixel_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic cam_pixel_clk,
  output logic pix_rise
);

  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], cam_pixel_clk};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign pix_rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/rgb_mean.sv
// Camera front-end: RGB444 pixels to 4-bit grey, written to a frame buffer by linear index.
// PIXEL_SIZE must be 12 (R=[11:8], G=[7:4], B=[3:0]).
module rgb_mean
  import rgb_mean_pkg::*;
#(
  parameter int unsigned CAMERA_HSIZE   = 100,
  parameter int unsigned CAMERA_VSIZE   = 100,
  parameter int unsigned PIXEL_SIZE     = 12,
  parameter int unsigned BUF_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cam_frame_valid,
  input  logic                      cam_line_valid,
  input  logic                      cam_pixel_clk,
  input  logic [PIXEL_SIZE-1:0]     cam_pixel_rgb,
  output logic [CHAN_W-1:0]         pixel_mean,
  output logic [BUF_ADDR_WIDTH-1:0] buf_waddr,
  output logic                      buf_wvalid,
  input  logic                      buf_wready,
  input  logic                      sad_done
);

  localparam int unsigned FramePix = CAMERA_HSIZE * CAMERA_VSIZE;
  localparam logic [BUF_ADDR_WIDTH-1:0] LastAddr = BUF_ADDR_WIDTH'(FramePix - 1);

  state_e                    state_q, state_d;
  logic [CHAN_W-1:0]         mean_q, mean_d;
  logic [BUF_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                      wvalid_q, wvalid_d;

  logic pix_rise;
  logic write_done;
  logic last_done;
  logic accept;

  pixel_edge_sync u_pixel_edge_sync (
    .clk           (clk),
    .rst_n         (rst_n),
    .cam_pixel_clk (cam_pixel_clk),
    .pix_rise      (pix_rise)
  );

  always_comb begin
    write_done = wvalid_q & buf_wready;
    last_done  = write_done & (waddr_q == LastAddr);
    // A pixel landing on the edge that finishes the frame must not start a new write.
    accept     = (state_q == StCapture) & pix_rise & cam_line_valid & cam_frame_valid &
                 (~wvalid_q | buf_wready) & ~last_done;

    state_d  = state_q;
    mean_d   = mean_q;
    waddr_d  = waddr_q;
    wvalid_d = wvalid_q;

    if (write_done) begin
      wvalid_d = 1'b0;
      waddr_d  = waddr_q + BUF_ADDR_WIDTH'(1);
    end

    if (accept) begin
      wvalid_d = 1'b1;
      mean_d   = mean3(cam_pixel_rgb[PIXEL_SIZE-1 -: CHAN_W],
                       cam_pixel_rgb[PIXEL_SIZE-CHAN_W-1 -: CHAN_W],
                       cam_pixel_rgb[CHAN_W-1:0]);
    end

    unique case (state_q)
      StIdle: begin
        // A write left over from an aborted frame keeps its address until it completes.
        if (!wvalid_q || buf_wready) begin
          waddr_d = '0;
        end
        if (cam_frame_valid && !wvalid_q) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (last_done) begin
          state_d = StWaitSad;
        end else if (!cam_frame_valid) begin
          state_d = StIdle;
        end
      end
      StWaitSad: begin
        if (sad_done) begin
          waddr_d = '0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mean_q   <= '0;
      waddr_q  <= '0;
      wvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mean_q   <= mean_d;
      waddr_q  <= waddr_d;
      wvalid_q <= wvalid_d;
    end
  end

  assign pixel_mean = mean_q;
  assign buf_waddr  = waddr_q;
  assign buf_wvalid = wvalid_q;

endmodule

// File: tb/tb_rgb_mean.sv
// Scoreboard bench for rgb_mean on a 4x2 frame.
module tb_rgb_mean;

  localparam int unsigned Hsize = 4;
  localparam int unsigned Vsize = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cam_frame_valid;
  logic        cam_line_valid;
  logic        cam_pixel_clk;
  logic [11:0] cam_pixel_rgb;
  logic [3:0]  pixel_mean;
  logic [31:0] buf_waddr;
  logic        buf_wvalid;
  logic        buf_wready;
  logic        sad_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_addr_q[$];
  logic [3:0]  exp_mean_q[$];
  logic [31:0] exp_addr;

  always #5 clk = ~clk;

  rgb_mean #(
    .CAMERA_HSIZE   (Hsize),
    .CAMERA_VSIZE   (Vsize),
    .PIXEL_SIZE     (12),
    .BUF_ADDR_WIDTH (32)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cam_frame_valid (cam_frame_valid),
    .cam_line_valid  (cam_line_valid),
    .cam_pixel_clk   (cam_pixel_clk),
    .cam_pixel_rgb   (cam_pixel_rgb),
    .pixel_mean      (pixel_mean),
    .buf_waddr       (buf_waddr),
    .buf_wvalid      (buf_wvalid),
    .buf_wready      (buf_wready),
    .sad_done        (sad_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_mean(input logic [11:0] rgb);
    int s;
    s = int'(rgb[11:8]) + int'(rgb[7:4]) + int'(rgb[3:0]);
    return 4'(s / 3);
  endfunction

  // Completed writes are popped from the scoreboard.
  always @(negedge clk) begin
    if (rst_n && buf_wvalid && buf_wready) begin
      check_eq("write_expected", (exp_addr_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_addr_q.size() > 0) begin
        check_eq("wr_addr", buf_waddr, exp_addr_q.pop_front());
        check_eq("wr_mean", 32'(pixel_mean), 32'(exp_mean_q.pop_front()));
      end
    end
  end

  task automatic send_pixel(input logic [11:0] rgb, input bit exp_wr, input bit lat);
    @(posedge clk);
    #1;
    cam_pixel_rgb = rgb;
    cam_pixel_clk = 1'b1;
    if (exp_wr) begin
      exp_addr_q.push_back(exp_addr);
      exp_mean_q.push_back(model_mean(rgb));
      exp_addr = exp_addr + 1;
    end
    // Edge i=0 is the first edge that samples the strobe high; output is due at i=2.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (lat) check_eq($sformatf("latency_edge%0d", i), 32'(buf_wvalid), (i == 2) ? 32'd1 : 32'd0);
    end
    cam_pixel_clk = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_addr_q.delete();
    exp_mean_q.delete();
    exp_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] pix_tab [5];
    pix_tab = '{12'hFFF, 12'h123, 12'hF00, 12'h0F1, 12'h000};

    rst_n           = 1'b0;
    cam_frame_valid = 1'b0;
    cam_line_valid  = 1'b0;
    cam_pixel_clk   = 1'b0;
    cam_pixel_rgb   = '0;
    buf_wready      = 1'b1;
    sad_done        = 1'b0;
    exp_addr        = '0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_wvalid", 32'(buf_wvalid), 32'd0);
    check_eq("rst_waddr", buf_waddr, 32'd0);
    check_eq("rst_mean", 32'(pixel_mean), 32'd0);
    rst_n = 1'b1;

    // Basic conversion, one-cycle writes, latency on the first pixel.
    cam_frame_valid = 1'b1;
    cam_line_valid  = 1'b1;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 5; i++) send_pixel(pix_tab[i], 1'b1, i == 0);
    check_eq("t2_drain", 32'(exp_addr_q.size()), 32'd0);

    // Reset asserted while a write is stalled.
    do_reset();
    buf_wready = 1'b0;
    send_pixel(12'hABC, 1'b1, 1'b0);
    check_eq("t1_wvalid_pre", 32'(buf_wvalid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t1_wvalid", 32'(buf_wvalid), 32'd0);
    check_eq("t1_waddr", buf_waddr, 32'd0);
    check_eq("t1_mean", 32'(pixel_mean), 32'd0);
    exp_addr_q.delete();
    exp_mean_q.delete();
    exp_addr = '0;
    buf_wready = 1'b1;
    do_reset();

    // Backpressure: first write held, second pixel dropped.
    buf_wready = 1'b0;
    send_pixel(12'h3C9, 1'b1, 1'b0);
    send_pixel(12'hFF0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      check_eq("t3_hold_wvalid", 32'(buf_wvalid), 32'd1);
      check_eq("t3_hold_addr", buf_waddr, 32'd0);
      check_eq("t3_hold_mean", 32'(pixel_mean), 32'(model_mean(12'h3C9)));
    end
    buf_wready = 1'b1;
    repeat (2) @(posedge clk);
    send_pixel(12'h777, 1'b1, 1'b0);

    // Line invalid: strobes ignored, address unchanged.
    cam_line_valid = 1'b0;
    for (int i = 0; i < 5; i++) send_pixel(12'h555, 1'b0, 1'b0);
    #1;
    check_eq("t4_waddr", buf_waddr, exp_addr);
    check_eq("t4_wvalid", 32'(buf_wvalid), 32'd0);
    cam_line_valid = 1'b1;
    send_pixel(12'h9A4, 1'b1, 1'b0);

    // Full frame, stall in WAIT_SAD, release by sad_done.
    do_reset();
    for (int i = 0; i < Hsize * Vsize; i++) send_pixel(12'(32'h1A3 * i), 1'b1, 1'b0);
    send_pixel(12'hFFF, 1'b0, 1'b0);
    send_pixel(12'h123, 1'b0, 1'b0);
    check_eq("t5_drain", 32'(exp_addr_q.size()), 32'd0);
    @(posedge clk);
    #1;
    sad_done = 1'b1;
    @(posedge clk);
    #1;
    sad_done = 1'b0;
    check_eq("t5_sad_addr", buf_waddr, 32'd0);
    exp_addr = '0;
    repeat (2) @(posedge clk);
    send_pixel(12'hE2C, 1'b1, 1'b0);
    // sad_done during capture must not disturb the address.
    @(posedge clk);
    #1;
    sad_done = 1'b1;
    @(posedge clk);
    #1;
    sad_done = 1'b0;
    send_pixel(12'h4B6, 1'b1, 1'b0);

    // Frame aborted after three writes.
    do_reset();
    for (int i = 0; i < 3; i++) send_pixel(12'h2D8 + 12'(i), 1'b1, 1'b0);
    @(posedge clk);
    #1;
    cam_frame_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("t6_idle_addr", buf_waddr, 32'd0);
    exp_addr = '0;
    cam_frame_valid = 1'b1;
    repeat (2) @(posedge clk);
    send_pixel(12'h8F3, 1'b1, 1'b0);

    repeat (5) @(posedge clk);
    check_eq("final_drain", 32'(exp_addr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_mean.md
Name: rgb_mean

Overview:
- Front-end of the SAD disparity pipeline.
- Samples a slow camera pixel interface (cam_pixel_clk is treated as a data signal in the clk domain) and converts each 12-bit RGB444 pixel to a 4-bit grey value: floor((R+G+B)/3).
- Writes each grey value to a frame buffer through a valid/ready write port with a linear address.
- After a full frame it stalls until the downstream SAD engine signals sad_done.

Parameters:
- CAMERA_HSIZE, 100, pixels per line.
- CAMERA_VSIZE, 100, lines per frame.
- PIXEL_SIZE, 12, RGB pixel width. Must be 12: three 4-bit channels, R=[11:8], G=[7:4], B=[3:0].
- BUF_ADDR_WIDTH, 32, buffer write-address width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- cam_frame_valid  input  1  camera frame-active level
- cam_line_valid  input  1  camera line-active level
- cam_pixel_clk  input  1  camera pixel strobe; rising edge marks a new pixel
- cam_pixel_rgb  input  PIXEL_SIZE  pixel data; stable for at least 4 clk cycles after each cam_pixel_clk rise
- pixel_mean  output  4  grey value of the current write
- buf_waddr  output  BUF_ADDR_WIDTH  pixel index of the current write (row*CAMERA_HSIZE+col)
- buf_wvalid  output  1  write request
- buf_wready  input  1  buffer accepts the write
- sad_done  input  1  single-cycle pulse: SAD finished with the buffered frame

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values:
  - pixel_mean=0, buf_waddr=0, buf_wvalid=0.
  - State IDLE, synchroniser flops 0.
- cam_pixel_clk synchronisation: 2-flop synchroniser plus a delay flop. pix_rise = sync2 & ~sync3.
- Latency: if cam_pixel_clk is first sampled high at clk edge k, pixel_mean, buf_waddr and buf_wvalid update at edge k+2.
- Pixel accept: a pix_rise is accepted only when all of the following hold:
  - state is CAPTURE,
  - cam_line_valid=1 and cam_frame_valid=1,
  - no write is pending (buf_wvalid=0, or buf_wvalid=1 with buf_wready=1 in the same cycle).
  - Otherwise the pixel is dropped and the address does not advance.
- Arithmetic:
  - sum = R+G+B, 6-bit unsigned, range 0..45.
  - mean = floor(sum/3), range 0..15, exact for all inputs.
  - A constant-multiply implementation is allowed: (sum*43)>>7.
- Write handshake:
  - buf_wvalid rises with the new mean/address.
  - pixel_mean and buf_waddr are held stable while buf_wvalid=1 and buf_wready=0.
  - The write completes on a clk edge with buf_wvalid & buf_wready. buf_wvalid then drops unless a new pixel is accepted on the same edge.
  - buf_waddr advances by 1 after each completed write.
- State machine:
  - IDLE: buf_waddr=0. Go to CAPTURE when cam_frame_valid=1 (level).
  - CAPTURE: accept pixels.
    - On completion of write index CAMERA_HSIZE*CAMERA_VSIZE-1, go to WAIT_SAD.
    - If cam_frame_valid falls before that, go to IDLE. Any pending write still completes; then the address returns to 0.
  - WAIT_SAD: ignore all pixel edges. On sad_done=1, set buf_waddr=0 and go to IDLE.
- sad_done in IDLE or CAPTURE has no effect.
- Asynchronous reset mid-write: buf_wvalid drops immediately and the write is abandoned.

Decomposition:
- Package rgb_mean_pkg holds:
  - state enum {IDLE, CAPTURE, WAIT_SAD},
  - CHAN_W=4,
  - a function mean3(r,g,b) returning floor((r+g+b)/3).
- One sub-module, pixel_edge_sync: 2-flop synchroniser plus rising-edge detector with async active-low reset, output pix_rise.

Test Plan:
1. Reset: assert rst_n=0 mid-write -> pixel_mean=0, buf_waddr=0, buf_wvalid=0 immediately.
2. buf_wready=1, frame/line valid high, pixels 12'hFFF, 12'h123, 12'hF00, 12'h0F1, 12'h000 -> writes (addr,mean) = (0,15), (1,2), (2,5), (3,5), (4,0). buf_wvalid is high 1 cycle each, arriving 2 clk edges after cam_pixel_clk is first sampled high.
3. Backpressure: buf_wready=0 for 30 cycles across two pixel edges -> first write (addr 0) held stable, second pixel dropped. After buf_wready=1 the next accepted pixel gets addr 1.
4. cam_line_valid=0 while cam_pixel_clk toggles 5 times -> no buf_wvalid, buf_waddr unchanged.
5. CAMERA_HSIZE=4, CAMERA_VSIZE=2 -> 8 writes at addr 0..7, then further pixels ignored. A sad_done pulse returns the block to addr 0, and the next pixel is written at addr 0.
6. cam_frame_valid falls after 3 writes -> IDLE. On cam_frame_valid re-assertion the first write is at addr 0.
